// File: rtl/z80_cdc_defs.sv
// Shared constants and helpers for the Z80 write/read CDC consumer blocks.
// The window-match helper is also used by the read-side blocks.
package z80_cdc_defs;

    localparam int Z80_DATA_WIDTH     = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    // Operands are zero-extended to 32 bits so one helper serves any address width up to 32.
    function automatic logic window_hit(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return ((addr ^ base) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO: the head entry is visible on rdata whenever empty=0.
// The caller is responsible for never pushing when full (unless popping) or popping when empty.
module fifo_sync #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Storage is deliberately left out of reset; stale contents are masked by empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wdata;
    end

    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/z80_wr_queue.sv
// Target-domain consumer of Z80 write ticks: edge-detects each write, filters it by an
// I/O address window and queues matching writes for a valid/ready peripheral port.
module z80_wr_queue
    import z80_cdc_defs::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int                    DEPTH_LOG2 = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(8'h40),
    parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = ADDR_WIDTH'(8'hF0)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_tick,
    input  logic [7:0]            din,
    input  logic [ADDR_WIDTH-1:0] ain,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [7:0]            out_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clear
);

    localparam int DW = Z80_DATA_WIDTH;
    localparam int EW = ADDR_WIDTH + DW;

    logic                tick_q_reg;
    logic                overflow_reg;
    logic                overflow_next;
    logic                wr_evt;
    logic                hit;
    logic                push_req;
    logic                push;
    logic                pop;
    logic [EW-1:0]       head;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    assign wr_evt   = wr_tick & ~tick_q_reg;
    assign hit      = window_hit(32'(ain), 32'(BASE_ADDR), 32'(ADDR_MASK));
    assign push_req = wr_evt & hit;
    assign pop      = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = push_req & (~fifo_full | pop);

    always_comb begin
        overflow_next = overflow_reg;
        if (push_req & fifo_full & ~pop) begin
            overflow_next = 1'b1;
        end else if (ovf_clear) begin
            overflow_next = 1'b0;
        end
    end

    // tick_q resets high so a tick already asserted when reset releases is not an event.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q_reg   <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            tick_q_reg   <= wr_tick;
            overflow_reg <= overflow_next;
        end
    end

    fifo_sync #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({ain, din}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_addr  = out_valid ? head[EW-1:DW] : '0;
    assign out_data  = out_valid ? head[DW-1:0]  : '0;
    assign count     = fifo_count;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_z80_wr_queue.sv
// Bench for z80_wr_queue: directed vector table, then randomized traffic against a queue model.
module tb_z80_wr_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_tick;
    logic [7:0] din;
    logic [7:0] ain;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       overflow;
    logic       ovf_clear;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    z80_wr_queue dut (
        .clk       (clk),
        .reset     (reset),
        .wr_tick   (wr_tick),
        .din       (din),
        .ain       (ain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    // Reference model: a plain queue of {addr,data} with capacity 4.
    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;
    ent_t mq[$];
    logic m_prev = 1'b1;
    logic m_ovf  = 1'b0;

    function automatic void model_step(logic rst, logic tick, logic [7:0] a, logic [7:0] d,
                                       logic rdy, logic clr);
        logic evt, in_win, pm, preq, is_full;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_prev = 1'b1;
            m_ovf  = 1'b0;
            return;
        end
        evt     = tick && !m_prev;
        in_win  = (a[7:4] == 4'h4);
        pm      = (mq.size() > 0) && rdy;
        preq    = evt && in_win;
        is_full = (mq.size() == 4);
        if (preq && is_full && !pm) m_ovf = 1'b1;
        else if (clr)               m_ovf = 1'b0;
        if (pm) void'(mq.pop_front());
        if (preq && (!is_full || pm)) begin
            e.a = a;
            e.d = d;
            mq.push_back(e);
        end
        m_prev = tick;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(logic rst, logic tick, logic [7:0] a, logic [7:0] d, logic rdy, logic clr);
        reset     = rst;
        wr_tick   = tick;
        ain       = a;
        din       = d;
        out_ready = rdy;
        ovf_clear = clr;
        model_step(rst, tick, a, d, rdy, clr);
        @(posedge clk);
        #1;
        chk("model_valid", int'(out_valid), int'(mq.size() > 0));
        chk("model_count", int'(count), mq.size());
        chk("model_ovf",   int'(overflow), int'(m_ovf));
        chk("model_addr",  int'(out_addr), (mq.size() > 0) ? int'(mq[0].a) : 0);
        chk("model_data",  int'(out_data), (mq.size() > 0) ? int'(mq[0].d) : 0);
    endtask

    typedef struct {
        logic       rst, tick;
        logic [7:0] a, d;
        logic       rdy, clr;
        logic       valid;
        logic [7:0] addr, data;
        logic [2:0] cnt;
        logic       ovf;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(logic rst, logic tick, logic [7:0] a, logic [7:0] d, logic rdy,
                                logic clr, logic valid, logic [7:0] addr, logic [7:0] data,
                                logic [2:0] cnt, logic ovf);
        vec_t v;
        v.rst = rst; v.tick = tick; v.a = a; v.d = d; v.rdy = rdy; v.clr = clr;
        v.valid = valid; v.addr = addr; v.data = data; v.cnt = cnt; v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    initial begin
        // Reset state, then one idle cycle so tick_q drops low.
        add(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        // Single write held two cycles: exactly one entry.
        add(0, 1, 8'h42, 8'hA5, 0, 0, 1, 8'h42, 8'hA5, 1, 0);
        add(0, 1, 8'h42, 8'hA5, 0, 0, 1, 8'h42, 8'hA5, 1, 0);
        add(0, 0, 8'h42, 8'hA5, 0, 0, 1, 8'h42, 8'hA5, 1, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        // Out-of-window write ignored.
        add(0, 1, 8'h52, 8'h11, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 8'h52, 8'h11, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        // Five writes into a 4-deep FIFO: last one dropped.
        for (int k = 1; k <= 5; k++) begin
            add(0, 1, 8'(8'h40 + k), 8'(k), 0, 0, 1, 8'h41, 8'h01, 3'((k > 4) ? 4 : k), k == 5);
            add(0, 0, 8'(8'h40 + k), 8'(k), 0, 0, 1, 8'h41, 8'h01, 3'((k > 4) ? 4 : k), k == 5);
        end
        // Drain 1..4 on consecutive cycles.
        for (int k = 1; k <= 4; k++) begin
            add(0, 0, 8'h00, 8'h00, 1, 0, k < 4, (k < 4) ? 8'(8'h41 + k) : 8'h00,
                (k < 4) ? 8'(k + 1) : 8'h00, 3'(4 - k), 1);
        end
        add(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 1);
        add(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0, 0);
        // Refill with 0x20..0x23.
        for (int k = 0; k < 4; k++) begin
            add(0, 1, 8'(8'h40 + k), 8'(8'h20 + k), 0, 0, 1, 8'h40, 8'h20, 3'(k + 1), 0);
            add(0, 0, 8'(8'h40 + k), 8'(8'h20 + k), 0, 0, 1, 8'h40, 8'h20, 3'(k + 1), 0);
        end
        // Drop and clear in the same cycle: set wins; clear alone next cycle.
        add(0, 1, 8'h4F, 8'h99, 0, 1, 1, 8'h40, 8'h20, 4, 1);
        add(0, 0, 8'h4F, 8'h99, 0, 1, 1, 8'h40, 8'h20, 4, 0);
        // Full with simultaneous pop: push accepted, count stays 4.
        add(0, 1, 8'h4E, 8'h77, 1, 0, 1, 8'h41, 8'h21, 4, 0);
        add(0, 0, 8'h4E, 8'h77, 0, 0, 1, 8'h41, 8'h21, 4, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h42, 8'h22, 3, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h43, 8'h23, 2, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h4E, 8'h77, 1, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        // Three entries queued, then reset with wr_tick held across deassertion.
        for (int k = 0; k < 3; k++) begin
            add(0, 1, 8'(8'h40 + k), 8'(8'h30 + k), 0, 0, 1, 8'h40, 8'h30, 3'(k + 1), 0);
            add(0, 0, 8'(8'h40 + k), 8'(8'h30 + k), 0, 0, 1, 8'h40, 8'h30, 3'(k + 1), 0);
        end
        add(1, 1, 8'h45, 8'h55, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 8'h45, 8'h55, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 8'h45, 8'h55, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 8'h45, 8'h55, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 8'h45, 8'h55, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 8'h45, 8'h55, 0, 0, 1, 8'h45, 8'h55, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].tick, vecs[i].a, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            chk("vec_valid", int'(out_valid), int'(vecs[i].valid));
            chk("vec_addr",  int'(out_addr),  int'(vecs[i].addr));
            chk("vec_data",  int'(out_data),  int'(vecs[i].data));
            chk("vec_count", int'(count),     int'(vecs[i].cnt));
            chk("vec_ovf",   int'(overflow),  int'(vecs[i].ovf));
            $display("vec %0d: tick=%0b ain=%02h din=%02h rdy=%0b -> valid=%0b addr=%02h data=%02h count=%0d ovf=%0b",
                     i, vecs[i].tick, vecs[i].a, vecs[i].d, vecs[i].rdy,
                     out_valid, out_addr, out_data, count, overflow);
        end

        // Randomized traffic; wr_tick toggles so writes span one or more cycles.
        begin
            logic       t = 1'b0;
            logic [7:0] a = 8'h40;
            logic [7:0] d = 8'h00;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 2) == 0) begin
                    if (!t) begin
                        a = ($urandom_range(0, 3) != 0) ? {4'h4, 4'($urandom_range(0, 15))}
                                                        : 8'($urandom_range(0, 255));
                        d = 8'($urandom_range(0, 255));
                    end
                    t = ~t;
                end
                apply($urandom_range(0, 199) == 0, t, a, d,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
